// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
//   Shared constants for the EX/MEM pipeline stage: condition-flag bit
//   positions inside the 3-bit ALU flag vector and the default widths of the
//   beat payload fields.
//   Build option: EX_MEM_SKID_EN (consumed by ex_mem_stage) selects the
//   two-entry skid configuration.
package ex_mem_pkg;

  // Flag bit positions in ex_flags / flags_q
  localparam int FLAG_OVF  = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_W    = 3;

  // Default payload field widths
  localparam int EXM_DATA_W = 32;
  localparam int EXM_OP_W   = 6;
  localparam int EXM_REG_AW = 5;

  // Total packed width of one beat for a given set of field widths:
  // opcode + result + flags + flags_we + wr_en + wr_addr + store_data
  function automatic int beat_width(input int data_w, input int op_w, input int reg_aw);
    return op_w + data_w + FLAG_W + 1 + 1 + reg_aw + data_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
//   Generic valid/ready buffer over a packed payload.
//   SKID_EN=1 : two entries (main = oldest, drives the output; skid = newest).
//               o_ready is a pure register term (~skid_valid).
//   SKID_EN=0 : single main entry, o_ready = ~main_valid | i_ready.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     flush               clear all valid bits at the edge, drop the input beat
//     i_valid/o_ready     upstream handshake, i_data payload
//     o_valid/i_ready     downstream handshake, o_data payload (main entry)
//     o_drain             downstream handshake completes this cycle
//     o_new_valid/o_new_data  newest held entry (skid if valid, else main)
import ex_mem_pkg::*;

module pipe_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_drain,
  output logic         o_new_valid,
  output logic [W-1:0] o_new_data
);

  logic         r_main_v;
  logic [W-1:0] r_main_d;
  logic         w_ready;
  logic         w_acc;
  logic         w_drain;

  // A drain still completes in a flush cycle, so it is not gated by flush.
  assign w_drain = r_main_v & i_ready;
  assign w_acc   = i_valid & w_ready & ~flush;

  assign o_ready = w_ready;
  assign o_valid = r_main_v;
  assign o_data  = r_main_d;
  assign o_drain = w_drain;

  generate
    if (SKID_EN) begin : g_skid
      logic         r_skid_v;
      logic [W-1:0] r_skid_d;
      logic         w_acc_main;

      assign w_ready = ~r_skid_v;

      // Incoming beat goes to main only when main is (or is becoming) free
      // and nothing older is waiting in skid.
      assign w_acc_main = w_acc & (~r_main_v | (w_drain & ~r_skid_v));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end else if (flush) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end else begin
          if (w_drain && r_skid_v) begin
            r_main_v <= 1'b1;
          end else if (w_acc_main) begin
            r_main_v <= 1'b1;
          end else if (w_drain) begin
            r_main_v <= 1'b0;
          end

          if (w_acc && !w_acc_main) begin
            r_skid_v <= 1'b1;
          end else if (w_drain) begin
            r_skid_v <= 1'b0;
          end
        end
      end

      // Payload is not reset; the valid bits qualify it.
      always_ff @(posedge clk) begin
        if (w_drain && r_skid_v) begin
          r_main_d <= r_skid_d;
        end else if (w_acc_main) begin
          r_main_d <= i_data;
        end
        if (w_acc && !w_acc_main) begin
          r_skid_d <= i_data;
        end
      end

      assign o_new_valid = r_skid_v | r_main_v;
      assign o_new_data  = r_skid_v ? r_skid_d : r_main_d;
    end else begin : g_noskid
      assign w_ready = ~r_main_v | i_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_v <= 1'b0;
        end else if (flush) begin
          r_main_v <= 1'b0;
        end else if (w_acc) begin
          r_main_v <= 1'b1;
        end else if (w_drain) begin
          r_main_v <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (w_acc) begin
          r_main_d <= i_data;
        end
      end

      assign o_new_valid = r_main_v;
      assign o_new_data  = r_main_d;
    end
  endgenerate

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX/MEM pipeline register. Captures each ALU beat (result, flags,
//   writeback control, store data), hands it to the memory stage over
//   valid/ready, holds the architectural flag register and exports a
//   forwarding view of the newest held beat.
//   Build option: define EX_MEM_SKID_EN for the two-entry skid buffer
//   (registered ex_ready); undefined gives a single entry with
//   ex_ready = ~mem_valid | mem_ready.
//   Ports:
//     clk, rst_n, flush                 clock, async active-low reset, flush
//     ex_valid/ex_ready + ex_* payload  execute-stage side
//     mem_valid/mem_ready + mem_*       memory-stage side (oldest beat)
//     flags_q                           architectural flags {neg, zero, ovf}
//     fwd_valid/fwd_addr/fwd_data       newest held writeback for bypass
import ex_mem_pkg::*;

module ex_mem_stage #(
  parameter int DATA_W = EXM_DATA_W,
  parameter int OP_W   = EXM_OP_W,
  parameter int REG_AW = EXM_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [OP_W-1:0]   ex_opcode,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [FLAG_W-1:0] ex_flags,
  input  logic              ex_flags_we,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [OP_W-1:0]   mem_opcode,
  output logic [DATA_W-1:0] mem_result,
  output logic              mem_wr_en,
  output logic [REG_AW-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [FLAG_W-1:0] flags_q,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

`ifdef EX_MEM_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic              flags_we;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] store_data;
  } beat_t;

  localparam int BEAT_W = beat_width(DATA_W, OP_W, REG_AW);

  beat_t             w_in_beat;
  beat_t             w_main_beat;
  beat_t             w_new_beat;
  logic              w_new_valid;
  logic              w_drain;
  logic [FLAG_W-1:0] r_flags;

  always_comb begin
    w_in_beat                  = '0;
    w_in_beat.opcode           = ex_opcode;
    w_in_beat.result           = ex_result;
    w_in_beat.flags[FLAG_OVF]  = ex_flags[FLAG_OVF];
    w_in_beat.flags[FLAG_ZERO] = ex_flags[FLAG_ZERO];
    w_in_beat.flags[FLAG_NEG]  = ex_flags[FLAG_NEG];
    w_in_beat.flags_we         = ex_flags_we;
    w_in_beat.wr_en            = ex_wr_en;
    w_in_beat.wr_addr          = ex_wr_addr;
    w_in_beat.store_data       = ex_store_data;
  end

  pipe_skid_buf #(
    .W       (BEAT_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .i_valid     (ex_valid),
    .o_ready     (ex_ready),
    .i_data      (w_in_beat),
    .o_valid     (mem_valid),
    .i_ready     (mem_ready),
    .o_data      (w_main_beat),
    .o_drain     (w_drain),
    .o_new_valid (w_new_valid),
    .o_new_data  (w_new_beat)
  );

  // Flags commit only when their beat actually leaves toward memory, so a
  // flushed beat can never disturb the architectural flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_drain && w_main_beat.flags_we) begin
      r_flags <= w_main_beat.flags;
    end
  end

  assign flags_q        = r_flags;
  assign mem_opcode     = w_main_beat.opcode;
  assign mem_result     = w_main_beat.result;
  assign mem_wr_en      = w_main_beat.wr_en;
  assign mem_wr_addr    = w_main_beat.wr_addr;
  assign mem_store_data = w_main_beat.store_data;

  assign fwd_valid = w_new_valid & w_new_beat.wr_en;
  assign fwd_addr  = w_new_beat.wr_addr;
  assign fwd_data  = w_new_beat.result;

endmodule
